hilo_mul_ctrl: RTL and testbench
================================

// Module: hilo_mul_ctrl
// PURPOSE
// Requester/consumer side of the multiplier result handshake. Takes a mult/multu op
// from the execute stage and issues a one-cycle start to the multiplier. Accepts its
// 64-bit result via mul_res_valid/mul_res_ready and writes the architectural HI/LO
// registers. Generates the pipeline stall, serves MTHI/MTLO, and drains stale results
// after a flush.
// PARAMETERS
// DRAIN_MAX  4   max cycles DRAIN waits for a stale mul_res_valid before returning to IDLE
// HILO_RST   0   32-bit reset value of HI and LO
// PORTS
// clk            in   1   clock
// rst            in   1   synchronous, active-high reset
// op_valid       in   1   mult op present in E stage; held while stall=1
// op_signed      in   1   1=mult, 0=multu
// op_a, op_b     in   32  operands
// op_acc         in   2   00 write, 01 add, 10 sub (only with HILO_ACC_EN)
// flush          in   1   pipeline flush; kills the in-flight op
// mul_valid      out  1   multiplier start strobe
// mul_issign     out  1   signedness to multiplier
// mul_a, mul_b   out  32  latched operands to multiplier
// mul_res_valid  in   1   multiplier result valid
// mul_res_ready  out  1   this block accepts the result
// mul_result     in   64  {hi,lo} product
// mthi_we        in   1   write HI from mt_data
// mtlo_we        in   1   write LO from mt_data
// mt_data        in   32  MTHI/MTLO data
// hi_o, lo_o     out  32  architectural HI/LO (registered)
// stall          out  1   hold upstream pipeline (combinational)
// done           out  1   one-cycle pulse: HI/LO updated from a product
// BEHAVIOUR
// - Reset: state=IDLE; hi_o=lo_o=HILO_RST; mul_valid=mul_res_ready=done=0; mul_a/b/issign=0.
// - FSM states: IDLE, REQ, WAIT, DRAIN.
// - IDLE: if op_valid & ~flush, latch op_a/op_b/op_signed (and op_acc), then go to REQ.
// - REQ: mul_valid=1 for exactly this one cycle, then go to WAIT.
// - WAIT: mul_res_ready=1. When mul_res_valid=1, the handshake completes in that cycle.
//   On the next edge: HI/LO=mul_result; done=1 for one cycle; go to IDLE.
// - flush in REQ or WAIT: go to DRAIN. The result is never written to HI/LO.
//   flush in WAIT in the same cycle as mul_res_valid: the result is discarded.
// - DRAIN: mul_res_ready=1. Any mul_res_valid seen here is accepted and dropped.
//   Return to IDLE on that handshake or after DRAIN_MAX cycles, whichever comes first.
// - stall = (state!=IDLE & state!=DRAIN) | (state==IDLE & op_valid & ~flush)
//           | (state==DRAIN & op_valid).
// - Latency: op accepted at T; mul_valid at T+1; HI/LO visible and done=1 one cycle after
//   the mul_res_valid handshake. With the 2-cycle multiplier, hi_o/lo_o are valid at T+5.
// - mthi_we/mtlo_we apply only in IDLE and only when no op is accepted that cycle.
//   Otherwise they are dropped; stall=1 obliges upstream to hold them.
//   mthi_we and mtlo_we together write both HI and LO.
// - rst mid-operation: back to IDLE at once. A later stale mul_res_valid is ignored
//   (ready=0 in IDLE).
// - mul_a/mul_b/mul_issign are held stable from REQ until IDLE.
// CONFIGURATION
// HILO_ACC_EN defined: op_acc port exists. On result, {hi,lo} = {hi,lo} + mul_result (01)
//   or {hi,lo} - mul_result (10), 64-bit modulo. Supports madd/msub.
// HILO_ACC_EN undefined: op_acc is absent and the result always overwrites HI/LO.
// TESTING
// 1. multu FFFFFFFF*FFFFFFFF -> hi_o=FFFFFFFE, lo_o=00000001; done=1 for one cycle; mul_valid high once.
// 2. mult signed 3*FFFFFFFE (-2) -> hi_o=FFFFFFFF, lo_o=FFFFFFFA; stall high from T through T+4.
// 3. flush in WAIT, then result arrives -> hi_o/lo_o unchanged; result accepted in DRAIN; IDLE after.
// 4. flush in REQ with no result ever -> DRAIN exits after 4 cycles; a following op completes normally.
// 5. mthi_we=1, mt_data=12345678 in IDLE -> hi_o=12345678; the same write during WAIT is dropped.
// 6. HILO_ACC_EN: hi/lo=0/00000010, madd 2*3 -> lo_o=00000016; msub 8*1 -> lo_o=0000000E.

Source files
------------

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: issues mult/multu to the external multiplier, owns HI/LO, serves MTHI/MTLO.
// Latency: op accepted at T, start strobe at T+1, HI/LO and done one cycle after the result handshake.
// Backpressure: stall holds the pipeline while an op is outstanding; results are taken only in WAIT/DRAIN.
// Optional feature macro: HILO_ACC_EN adds op_acc and madd/msub accumulation into {HI,LO}.
module hilo_mul_ctrl #(
  parameter int unsigned DRAIN_MAX = 4,
  parameter logic [31:0] HILO_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef HILO_ACC_EN
  input  logic [1:0]  op_acc,
`endif
  input  logic        flush,
  output logic        mul_valid,
  output logic        mul_issign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_res_valid,
  output logic        mul_res_ready,
  input  logic [63:0] mul_result,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall,
  output logic        done
);

  // Drain counter only needs to reach DRAIN_MAX-1.
  localparam int unsigned CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]   opa_q, opa_d;
  logic [31:0]   opb_q, opb_d;
  logic          sgn_q, sgn_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;
  logic [63:0]   res_hilo;
`ifdef HILO_ACC_EN
  logic [1:0]    acc_q, acc_d;
`endif

  logic op_accept;   // new op taken this cycle
  logic res_commit;  // product handshake that must land in HI/LO
  logic drain_exit;  // DRAIN finished (stale result absorbed or timed out)
  logic mt_en;       // MTHI/MTLO may write this cycle

  assign op_accept  = (state_q == S_IDLE) & op_valid & ~flush;
  assign res_commit = (state_q == S_WAIT) & mul_res_valid & ~flush;
  assign drain_exit = (state_q == S_DRAIN) & (mul_res_valid | (drain_cnt_q == DRAIN_LAST));
  assign mt_en      = (state_q == S_IDLE) & ~op_accept;

  // State register; reset returns to IDLE immediately, abandoning any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush while the op is live always routes through DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (op_accept) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        state_d = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (mul_res_valid) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_exit) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs: start strobe, result ready and pipeline stall.
  always_comb begin
    mul_valid     = 1'b0;
    mul_res_ready = 1'b0;
    stall         = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall = op_valid & ~flush;
      end
      S_REQ: begin
        mul_valid = 1'b1;
        stall     = 1'b1;
      end
      S_WAIT: begin
        mul_res_ready = 1'b1;
        stall         = 1'b1;
      end
      S_DRAIN: begin
        mul_res_ready = 1'b1;
        stall         = op_valid;
      end
      default: begin
        mul_valid     = 1'b0;
        mul_res_ready = 1'b0;
        stall         = 1'b0;
      end
    endcase
  end

  // DRAIN cycle counter, cleared whenever we are outside DRAIN.
  always_comb begin
    drain_cnt_d = '0;
    if (state_q == S_DRAIN && !drain_exit) begin
      drain_cnt_d = drain_cnt_q + 1'b1;
    end
  end

  // Operand capture on accept; held unchanged until the next accepted op.
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    sgn_d = sgn_q;
`ifdef HILO_ACC_EN
    acc_d = acc_q;
`endif
    if (op_accept) begin
      opa_d = op_a;
      opb_d = op_b;
      sgn_d = op_signed;
`ifdef HILO_ACC_EN
      acc_d = op_acc;
`endif
    end
  end

  // Value written to {HI,LO} when a product commits (overwrite or accumulate).
  always_comb begin
    res_hilo = mul_result;
`ifdef HILO_ACC_EN
    case (acc_q)
      2'b01:   res_hilo = {hi_q, lo_q} + mul_result;
      2'b10:   res_hilo = {hi_q, lo_q} - mul_result;
      default: res_hilo = mul_result;
    endcase
`endif
  end

  // HI/LO next value: product commit in WAIT, otherwise MTHI/MTLO when idle and not accepting.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = res_commit;
    if (res_commit) begin
      hi_d = res_hilo[63:32];
      lo_d = res_hilo[31:0];
    end else if (mt_en) begin
      if (mthi_we) begin
        hi_d = mt_data;
      end
      if (mtlo_we) begin
        lo_d = mt_data;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sgn_q       <= 1'b0;
      hi_q        <= HILO_RST;
      lo_q        <= HILO_RST;
      done_q      <= 1'b0;
`ifdef HILO_ACC_EN
      acc_q       <= 2'b00;
`endif
    end else begin
      drain_cnt_q <= drain_cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sgn_q       <= sgn_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
`ifdef HILO_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign mul_a      = opa_q;
  assign mul_b      = opb_q;
  assign mul_issign = sgn_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: directed scenarios plus randomized ops against a behavioural model.
// A 2-cycle multiplier is modelled in the bench; its product is computed with plain arithmetic.
// Build with +define+HILO_ACC_EN to also exercise madd/msub.
`define CK(tag, o, e) chk(tag, 64'(o), 64'(e));

module tb_hilo_mul_ctrl;

  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;
  localparam int          MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, op_signed, flush;
  logic [31:0] op_a, op_b;
  logic [1:0]  op_acc;
  logic        mul_valid, mul_issign, mul_res_valid, mul_res_ready;
  logic [31:0] mul_a, mul_b;
  logic [63:0] mul_result;
  logic        mthi_we, mtlo_we;
  logic [31:0] mt_data, hi_o, lo_o;
  logic        stall, done;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_hi, m_lo;      // reference HI/LO
  logic [63:0] m_res;           // product the multiplier model will return
  int          m_cnt = 0;
  bit          mul_mute = 1'b0; // multiplier model ignores starts

  hilo_mul_ctrl #(.DRAIN_MAX(4), .HILO_RST(RST_VAL)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_signed(op_signed),
    .op_a(op_a), .op_b(op_b),
`ifdef HILO_ACC_EN
    .op_acc(op_acc),
`endif
    .flush(flush), .mul_valid(mul_valid), .mul_issign(mul_issign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res_valid(mul_res_valid),
    .mul_res_ready(mul_res_ready), .mul_result(mul_result),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .hi_o(hi_o), .lo_o(lo_o), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; also advances the multiplier model (start -> result MUL_LAT+1 cycles later, held until taken).
  task automatic tick();
    bit hs, mv;
    hs = mul_res_valid && mul_res_ready;
    mv = mul_valid;
    @(posedge clk);
    #1;
    if (hs) begin
      mul_res_valid = 1'b0;
      mul_result    = {$urandom, $urandom};
    end
    if (mv && !mul_mute) begin
      m_cnt = MUL_LAT;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        mul_res_valid = 1'b1;
        mul_result    = m_res;
      end
    end
  endtask

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ua = a;
    ub = b;
    return sgn ? 64'(sa * sb) : 64'(ua * ub);
  endfunction

  // Issue one op. flush_at<0: no flush, else flush in cycle T+flush_at. resp=0: multiplier never answers.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [1:0] acc, input int flush_at, input bit resp, input bit mt_in_t);
    logic [63:0] prod, nxt;
    int last_rdy, stall_end;
    prod = product(a, b, sgn);
    nxt  = prod;
`ifdef HILO_ACC_EN
    if (acc == 2'b01) nxt = {m_hi, m_lo} + prod;
    else if (acc == 2'b10) nxt = {m_hi, m_lo} - prod;
`endif
    m_res    = prod;
    mul_mute = !resp;
    if (flush_at < 0) begin
      last_rdy  = 4;
      stall_end = 4;
    end else begin
      stall_end = flush_at;
      last_rdy  = (resp && flush_at <= 3) ? 4 : flush_at + 4;
    end
    op_valid = 1'b1; op_a = a; op_b = b; op_signed = sgn; op_acc = acc;
    mthi_we = mt_in_t; mtlo_we = 1'b0; mt_data = $urandom; flush = 1'b0;
    #1;
    `CK("stall_accept", stall, 1'b1)
    tick();
    op_valid = 1'b0; mthi_we = 1'b0;
    op_a = $urandom; op_b = $urandom; op_signed = 1'($urandom_range(0, 1));
    for (int k = 1; k <= last_rdy + 2; k++) begin
      if (k == flush_at) flush = 1'b1;
      if (k == 3) begin
        mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = $urandom;
      end
      #1;
      n_chk++;
      if (mul_valid !== (k == 1)) begin
        n_fail++;
        $error("FAIL mul_valid_inl: cycle %0d observed %0b", k, mul_valid);
      end
      n_chk++;
      if (done !== ((flush_at < 0) && (k == 5))) begin
        n_fail++;
        $error("FAIL done_inl: cycle %0d observed %0b", k, done);
      end
      `CK("mul_valid", mul_valid, k == 1)
      `CK("stall", stall, k <= stall_end)
      `CK("res_ready", mul_res_ready, (k >= 2) && (k <= last_rdy))
      `CK("done", done, (flush_at < 0) && (k == 5))
      `CK("mul_a_held", mul_a, a)
      `CK("mul_b_held", mul_b, b)
      `CK("mul_issign_held", mul_issign, sgn)
      if (k == 5 && flush_at < 0) begin
        m_hi = nxt[63:32];
        m_lo = nxt[31:0];
      end
      `CK("hi", hi_o, m_hi)
      `CK("lo", lo_o, m_lo)
      tick();
      flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    end
    mul_mute = 1'b0;
  endtask

  // MTHI/MTLO in IDLE, optionally alongside a flushed (hence not accepted) op.
  task automatic mt_write(input bit hw, input bit lw, input logic [31:0] d, input bit with_flushed_op);
    mthi_we = hw; mtlo_we = lw; mt_data = d;
    op_valid = with_flushed_op; flush = with_flushed_op; op_a = $urandom; op_b = $urandom;
    #1;
    `CK("stall_idle", stall, 1'b0)
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0; op_valid = 1'b0; flush = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    `CK("mt_hi", hi_o, m_hi)
    `CK("mt_lo", lo_o, m_lo)
    `CK("mt_no_start", mul_valid, 1'b0)
  endtask

  initial begin
    int fa;
    bit rs;
    logic [1:0] acc;
    rst = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_a = '0; op_b = '0; op_acc = 2'b00;
    flush = 1'b0; mul_res_valid = 1'b0; mul_result = '0;
    mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
    m_hi = RST_VAL; m_lo = RST_VAL;
    tick(); tick();
    rst = 1'b0;
    #1;
    `CK("rst_hi", hi_o, RST_VAL)
    `CK("rst_lo", lo_o, RST_VAL)
    `CK("rst_mul_valid", mul_valid, 1'b0)
    `CK("rst_ready", mul_res_ready, 1'b0)
    `CK("rst_done", done, 1'b0)
    `CK("rst_stall", stall, 1'b0)
    `CK("rst_mul_a", mul_a, 32'h0)
    `CK("rst_mul_b", mul_b, 32'h0)
    `CK("rst_issign", mul_issign, 1'b0)

    // multu max*max, then signed 3 * -2
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00, -1, 1'b1, 1'b0);
    `CK("multu_hi", hi_o, 32'hFFFF_FFFE)
    `CK("multu_lo", lo_o, 32'h0000_0001)
    run_op(32'h0000_0003, 32'hFFFF_FFFE, 1'b1, 2'b00, -1, 1'b1, 1'b1);
    `CK("mult_hi", hi_o, 32'hFFFF_FFFF)
    `CK("mult_lo", lo_o, 32'hFFFF_FFFA)

    // flush in WAIT with the result arriving in DRAIN; flush in REQ with no result ever
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2'b00, 2, 1'b1, 1'b0);
    run_op(32'h0000_0007, 32'h0000_0009, 1'b0, 2'b00, 1, 1'b0, 1'b0);
    run_op(32'h0000_0007, 32'h0000_0009, 1'b0, 2'b00, -1, 1'b1, 1'b0);
    `CK("after_drain_lo", lo_o, 32'd63)
    // flush coincident with the result
    run_op(32'h0000_0100, 32'h0000_0100, 1'b0, 2'b00, 4, 1'b1, 1'b0);

    // MTHI in IDLE, and alongside a flushed op
    mt_write(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    `CK("mthi_value", hi_o, 32'h1234_5678)
    mt_write(1'b1, 1'b1, 32'hCAFE_0001, 1'b1);

    // reset mid-op, stale result later ignored
    m_res = 64'h1111_2222_3333_4444;
    op_valid = 1'b1; op_a = 32'd5; op_b = 32'd7; op_signed = 1'b0;
    tick();
    op_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = RST_VAL; m_lo = RST_VAL;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (mul_res_ready !== 1'b0) begin
        n_fail++;
        $error("FAIL midrst_ready_inl: observed %0b", mul_res_ready);
      end
      n_chk++;
      if (hi_o !== m_hi) begin
        n_fail++;
        $error("FAIL midrst_hi_inl: observed %0h expected %0h", hi_o, m_hi);
      end
      n_chk++;
      if (lo_o !== m_lo) begin
        n_fail++;
        $error("FAIL midrst_lo_inl: observed %0h expected %0h", lo_o, m_lo);
      end
      n_chk++;
      if (done !== 1'b0) begin
        n_fail++;
        $error("FAIL midrst_done_inl: observed %0b", done);
      end
      `CK("midrst_ready", mul_res_ready, 1'b0)
      `CK("midrst_hi", hi_o, m_hi)
      `CK("midrst_lo", lo_o, m_lo)
      `CK("midrst_done", done, 1'b0)
      `CK("midrst_mul_a", mul_a, 32'h0)
      tick();
    end
    mul_res_valid = 1'b0; m_cnt = 0;

`ifdef HILO_ACC_EN
    mt_write(1'b1, 1'b1, 32'h0, 1'b0);
    mt_write(1'b0, 1'b1, 32'h10, 1'b0);
    run_op(32'd2, 32'd3, 1'b0, 2'b01, -1, 1'b1, 1'b0);
    `CK("madd_lo", lo_o, 32'h16)
    run_op(32'd8, 32'd1, 1'b0, 2'b10, -1, 1'b1, 1'b0);
    `CK("msub_lo", lo_o, 32'h0E)
`endif

    // randomized mix
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end else begin
        fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
        rs = (fa < 0) ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef HILO_ACC_EN
        acc = 2'($urandom_range(0, 2));
`else
        acc = 2'b00;
`endif
        run_op($urandom, $urandom, 1'($urandom_range(0, 1)), acc, fa, rs, 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
